// File: rtl/ahb_arbiter.sv
// ahb_arbiter: four-master round-robin AHB bus arbiter that never breaks a fixed-length burst.
// Optional locked transfers are enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic                   hmastlock
);
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstSingle = 3'b000;
    localparam logic [2:0] BurstIncr   = 3'b001;

    localparam logic [1:0]             DefaultIdx   = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DefaultGrant =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    typedef enum logic [1:0] {StIdle, StBurst, StIncr} state_e;

    state_e                 state_q, state_d, fresh_state;
    logic [4:0]             cnt_q, cnt_d, burst_len_m1;
    logic [1:0]             ptr_q, grant_idx, arb_idx, cand;
    logic [NUM_MASTERS-1:0] grant_d;
    logic                   is_nonseq, is_seq, fixed_burst, multi_beat;
    logic                   arb_found, arb_point, lock_hold;

    assign is_nonseq   = (htrans == TransNonseq);
    assign is_seq      = (htrans == TransSeq);
    assign fixed_burst = (hburst[2:1] != 2'b00);
    assign multi_beat  = (hburst != BurstSingle);

    always_comb begin
        unique case (hburst[2:1])
            2'b01:   burst_len_m1 = 5'd3;
            2'b10:   burst_len_m1 = 5'd7;
            2'b11:   burst_len_m1 = 5'd15;
            default: burst_len_m1 = 5'd0;
        endcase
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) grant_idx = 2'(i);
        end
    end

    // Search starts just past the current owner, so the owner itself is tried last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = DefaultIdx;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = ptr_q + 2'(k);
            if (!arb_found && hbusreq[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        grant_d          = '0;
        grant_d[arb_idx] = 1'b1;
    end

`ifdef AHB_ARB_LOCK_EN
    assign lock_hold = hlock[grant_idx];

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hmastlock <= 1'b0;
        end else if (hready) begin
            hmastlock <= hlock[grant_idx];
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^hlock;
    assign lock_hold   = 1'b0;
    assign hmastlock   = 1'b0;
`endif

    always_comb begin
        fresh_state = StIdle;
        if (is_nonseq && fixed_burst) begin
            fresh_state = StBurst;
        end else if (is_nonseq && hburst == BurstIncr) begin
            fresh_state = StIncr;
        end

        state_d   = state_q;
        arb_point = 1'b0;
        case (state_q)
            StIdle: begin
                state_d   = fresh_state;
                arb_point = !(is_nonseq && multi_beat);
            end
            StBurst: begin
                // Early grant on the last beat's address phase.
                if (is_seq && cnt_q == 5'd1) begin
                    state_d   = StIdle;
                    arb_point = 1'b1;
                end
            end
            StIncr: begin
                arb_point = !hbusreq[hmaster];
                if (htrans == TransIdle) begin
                    state_d = StIdle;
                end else if (is_nonseq) begin
                    state_d = fresh_state;
                end
            end
            default: state_d = StIdle;
        endcase
        if (lock_hold) arb_point = 1'b0;

        cnt_d = cnt_q;
        if (is_nonseq) begin
            cnt_d = burst_len_m1;
        end else if (is_seq && cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= DefaultIdx;
            hgrant  <= DefaultGrant;
            hmaster <= DefaultIdx;
        end else if (hready) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hmaster <= grant_idx;
            if (arb_point) begin
                hgrant <= grant_d;
                ptr_q  <= arb_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: table-driven directed vectors, hand sequences for reset/lock corners,
// and randomized traffic checked against a rule-level reference model.
module tb_ahb_arbiter;
    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, INC4 = 3'b011, INC8 = 3'b101;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = IDL;
    logic [2:0] hburst = SGL;
    logic       hready = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_arbiter dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [3:0] eg;
        logic [1:0] em;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] req, logic [1:0] trans, logic [2:0] burst,
                                logic rdy, logic [3:0] eg, logic [1:0] em);
        vec_t v;
        v.rst = rst; v.req = req; v.trans = trans; v.burst = burst; v.rdy = rdy;
        v.eg = eg; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input logic [1:0] em,
                              input logic el);
        check({tag, " hgrant"}, 32'(hgrant), 32'(eg));
        check({tag, " hmaster"}, 32'(hmaster), 32'(em));
        check({tag, " hmastlock"}, 32'(hmastlock), 32'(el));
        check({tag, " onehot"}, 32'($onehot(hgrant)), 32'd1);
    endtask

    task automatic step(input logic r, input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        hreset = r; hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
        @(posedge hclk);
        #1;
    endtask

    // Reference model: the grantee doubles as the round-robin pointer.
    int m_grant, m_owner, m_cnt, m_mode;  // mode: 0 idle, 1 fixed burst, 2 incr
    bit m_lock;

    function automatic int pick(int cur, logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(cur + k) % 4]) return (cur + k) % 4;
        end
        return 0;
    endfunction

    function automatic int burst_beats(logic [2:0] b);
        case (b[2:1])
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_cnt = 0; m_mode = 0; m_lock = 0;
    endtask

    task automatic model_step();
        int len, nxt_mode;
        bit arb, nonseq, seq;
        if (hreset) begin
            model_reset();
            return;
        end
        if (!hready) return;
        nonseq = (htrans == NSQ);
        seq    = (htrans == SEQ);
        len    = burst_beats(hburst);
        case (m_mode)
            0:       arb = !(nonseq && hburst != SGL);
            1:       arb = seq && m_cnt == 1;
            default: arb = !hbusreq[m_owner];
        endcase
`ifdef AHB_ARB_LOCK_EN
        if (hlock[m_grant]) arb = 0;
        m_lock = hlock[m_grant];
`endif
        nxt_mode = m_mode;
        if (nonseq && m_mode != 1) nxt_mode = (len > 1) ? 1 : ((hburst == INC) ? 2 : 0);
        else if (m_mode == 1 && seq && m_cnt == 1) nxt_mode = 0;
        else if (m_mode == 2 && htrans == IDL) nxt_mode = 0;
        if (nonseq) m_cnt = len - 1;
        else if (seq && m_cnt > 0) m_cnt = m_cnt - 1;
        m_owner = m_grant;
        if (arb) m_grant = pick(m_grant, hbusreq);
        m_mode = nxt_mode;
    endtask

    logic [3:0] lk_eg[4];
    logic [1:0] lk_em[4];
    logic       lk_el[4];

    initial begin
        // Reset and idle
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'b0000, IDL, SGL, 1, 4'b0001, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0000, IDL, SGL, 1, 4'b0001, 0));
        // Single requester: grant one edge later, ownership one more edge later
        vecs.push_back(mk(0, 4'b0100, NSQ, SGL, 1, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0100, NSQ, SGL, 1, 4'b0100, 2));
        // All requesting: rotation from pointer 0
        vecs.push_back(mk(1, 4'b0000, IDL, SGL, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b1111, NSQ, SGL, 1, 4'b0010, 0));
        vecs.push_back(mk(0, 4'b1111, NSQ, SGL, 1, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b1111, NSQ, SGL, 1, 4'b1000, 2));
        vecs.push_back(mk(0, 4'b1111, NSQ, SGL, 1, 4'b0001, 3));
        vecs.push_back(mk(0, 4'b1111, NSQ, SGL, 1, 4'b0010, 0));
        // Master 1 INCR4 with others waiting
        vecs.push_back(mk(0, 4'b0010, NSQ, SGL, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, NSQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b1011, IDL, SGL, 1, 4'b0001, 3));
        // INCR4 again with wait states on beat 2 and on the last beat
        vecs.push_back(mk(0, 4'b0010, NSQ, SGL, 1, 4'b0010, 0));
        vecs.push_back(mk(0, 4'b0010, NSQ, SGL, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, NSQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 0, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 0, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 0, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1011, SEQ, INC4, 1, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b1011, IDL, SGL, 0, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b1011, IDL, SGL, 1, 4'b0001, 3));
        // Undefined-length INCR: held while owner requests
        vecs.push_back(mk(0, 4'b0001, NSQ, SGL, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0011, NSQ, INC, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0011, SEQ, INC, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0010, SEQ, INC, 1, 4'b0010, 0));
        vecs.push_back(mk(0, 4'b0010, IDL, SGL, 1, 4'b0010, 1));

        @(negedge hclk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, 4'b0000, vecs[i].trans, vecs[i].burst, vecs[i].rdy);
            check_outs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].em, 1'b0);
        end

        // Asynchronous reset in the middle of an INCR8 burst
        step(0, 4'b0100, 4'b0000, NSQ, SGL, 1);
        step(0, 4'b0100, 4'b0000, NSQ, SGL, 1);
        check_outs("pre_burst", 4'b0100, 2'd2, 1'b0);
        step(0, 4'b0100, 4'b0000, NSQ, INC8, 1);
        step(0, 4'b0100, 4'b0000, SEQ, INC8, 1);
        #2 hreset = 1'b1;
        #1 check_outs("async_rst", 4'b0001, 2'd0, 1'b0);
        #1 hreset = 1'b0;
        step(0, 4'b0100, 4'b0000, SEQ, INC8, 1);
        check_outs("post_abort", 4'b0100, 2'd0, 1'b0);

        // Locked transfers by master 0 while master 1 waits
`ifdef AHB_ARB_LOCK_EN
        lk_eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        lk_em = '{2'd0, 2'd0, 2'd0, 2'd0};
        lk_el = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
        lk_eg = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
        lk_em = '{2'd0, 2'd1, 2'd0, 2'd1};
        lk_el = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        step(1, 4'b0000, 4'b0000, IDL, SGL, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0011, (i < 3) ? 4'b0001 : 4'b0000, NSQ, SGL, 1);
            check_outs($sformatf("lock%0d", i), lk_eg[i], lk_em[i], lk_el[i]);
        end

        // Randomized traffic against the reference model
        step(1, 4'b0000, 4'b0000, IDL, SGL, 1);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            hreset  = 1'b0;
            hbusreq = 4'($urandom);
            hlock   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            htrans  = 2'($urandom);
            hburst  = 3'($urandom);
            hready  = ($urandom_range(0, 3) != 0);
            @(posedge hclk);
            model_step();
            #1;
            check_outs($sformatf("rand%0d", n), 4'(1 << m_grant), 2'(m_owner), m_lock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
